intra_row_ref_ctrl: RTL and testbench

INTRA_ROW_REF_CTRL -- requirements
Module: intra_row_ref_ctrl

---
 rtl/intra_row_pkg.sv | 23 ++
 rtl/intra_row_addr_gen.sv | 60 ++++++
 rtl/intra_row_ref_ctrl.sv | 227 ++++++++++++++++++++++
 tb/tb_intra_row_ref_ctrl.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/intra_row_pkg.sv
// Shared sizes, default pad word and FSM state type for the intra top-reference row controller.
package intra_row_pkg;
    localparam int WORD_W    = 32;
    localparam int ADDR_W    = 9;
    localparam int LCU_WORDS = 16;
    localparam int REF_WORDS = 32;
    localparam int CNT_W     = 5;
    // Wide enough for 63*16+31, so base+offset never wraps before the range compare.
    localparam int EXT_W     = 11;

    localparam logic [WORD_W-1:0] DFLT_WORD = 32'h8080_8080;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RD    = 2'd1,
        DRAIN = 2'd2,
        WR    = 2'd3
    } state_e;

    function automatic logic [EXT_W-1:0] lcu_base(input logic [5:0] lcu_x);
        return {1'b0, lcu_x, 4'b0000};
    endfunction
endpackage

// File: rtl/intra_row_addr_gen.sv
// Base+offset word address counter with frame-width range compare for the current and next offset.
module intra_row_addr_gen
    import intra_row_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load_i,
    input  logic [5:0]        lcu_x_i,
    input  logic [ADDR_W-1:0] width_i,
    input  logic              step_i,
    input  logic              clr_i,
    output logic [CNT_W-1:0]  off_o,
    output logic [ADDR_W-1:0] cur_addr_o,
    output logic              cur_ok_o,
    output logic [ADDR_W-1:0] nxt_addr_o,
    output logic              nxt_ok_o
);
    logic [EXT_W-1:0]  base_q, base_d;
    logic [ADDR_W-1:0] width_q, width_d;
    logic [CNT_W-1:0]  off_q, off_d;
    logic [EXT_W-1:0]  cur_ext, nxt_ext;

    // Next-state of base/width/offset plus wide sums for the current and upcoming offsets.
    always_comb begin
        base_d  = base_q;
        width_d = width_q;
        if (load_i) begin
            base_d  = lcu_base(lcu_x_i);
            width_d = width_i;
            off_d   = {CNT_W{1'b0}};
        end else if (clr_i) begin
            off_d = {CNT_W{1'b0}};
        end else if (step_i) begin
            off_d = off_q + 5'd1;
        end else begin
            off_d = off_q;
        end
        cur_ext = base_q + {{(EXT_W-CNT_W){1'b0}}, off_q};
        nxt_ext = base_d + {{(EXT_W-CNT_W){1'b0}}, off_d};
    end

    // Counter state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            base_q  <= {EXT_W{1'b0}};
            width_q <= {ADDR_W{1'b0}};
            off_q   <= {CNT_W{1'b0}};
        end else begin
            base_q  <= base_d;
            width_q <= width_d;
            off_q   <= off_d;
        end
    end

    assign off_o      = off_q;
    assign cur_addr_o = cur_ext[ADDR_W-1:0];
    assign cur_ok_o   = (cur_ext < {2'b00, width_q});
    assign nxt_addr_o = nxt_ext[ADDR_W-1:0];
    assign nxt_ok_o   = (nxt_ext < {2'b00, width_d});
endmodule

// File: rtl/intra_row_ref_ctrl.sv
// Intra top/top-right reference row reader and bottom-row writer for one LCU.
// Define INTRA_TOPRIGHT_PAD_EN to pad out-of-frame slots with the last RAM word instead of 0x80808080.
module intra_row_ref_ctrl
    import intra_row_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic [5:0]        lcu_x_i,
    input  logic [ADDR_W-1:0] frame_w_words_i,
    input  logic              first_row_i,
    output logic              ref_valid_o,
    output logic [WORD_W-1:0] ref_data_o,
    output logic [4:0]        ref_idx_o,
    output logic              ref_last_o,
    input  logic              wr_valid_i,
    input  logic [WORD_W-1:0] wr_data_i,
    output logic              wr_ready_o,
    output logic              done_o,
    output logic              ram_cen_o,
    output logic              ram_wen_o,
    output logic [ADDR_W-1:0] ram_addr_o,
    output logic [WORD_W-1:0] ram_data_o,
    input  logic [WORD_W-1:0] ram_data_i
);
    state_e            state_q, state_d;
    logic              first_row_q, first_row_d;
    logic              ref_valid_q, ref_valid_d;
    logic              ref_last_q, ref_last_d;
    logic              ref_hit_q, ref_hit_d;
    logic [4:0]        ref_idx_q, ref_idx_d;
    logic              wr_ready_q, wr_ready_d;
    logic              done_q, done_d;
    logic              ram_cen_q, ram_cen_d;
    logic              ram_wen_q, ram_wen_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic [WORD_W-1:0] ram_data_q, ram_data_d;
    logic [WORD_W-1:0] pad_word;

    logic              load, step, clr;
    logic [CNT_W-1:0]  off;
    logic [ADDR_W-1:0] cur_addr, nxt_addr;
    logic              cur_ok, nxt_ok;

    intra_row_addr_gen u_addr_gen (
        .clk        (clk),
        .rst        (rst),
        .load_i     (load),
        .lcu_x_i    (lcu_x_i),
        .width_i    (frame_w_words_i),
        .step_i     (step),
        .clr_i      (clr),
        .off_o      (off),
        .cur_addr_o (cur_addr),
        .cur_ok_o   (cur_ok),
        .nxt_addr_o (nxt_addr),
        .nxt_ok_o   (nxt_ok)
    );

    // RAM outputs always carry the slot for the upcoming cycle, so a slot's data returns exactly one cycle later.
    always_comb begin
        state_d     = state_q;
        first_row_d = first_row_q;
        ref_valid_d = 1'b0;
        ref_last_d  = 1'b0;
        ref_hit_d   = 1'b0;
        ref_idx_d   = 5'd0;
        wr_ready_d  = 1'b0;
        done_d      = 1'b0;
        ram_cen_d   = 1'b1;
        ram_wen_d   = 1'b1;
        ram_addr_d  = {ADDR_W{1'b0}};
        ram_data_d  = {WORD_W{1'b0}};
        load        = 1'b0;
        step        = 1'b0;
        clr         = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    load        = 1'b1;
                    first_row_d = first_row_i;
                    state_d     = RD;
                    if (!first_row_i && nxt_ok) begin
                        ram_cen_d  = 1'b0;
                        ram_addr_d = nxt_addr;
                    end else begin
                        ram_cen_d  = 1'b1;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            RD: begin
                ref_valid_d = 1'b1;
                ref_idx_d   = off;
                ref_hit_d   = ~ram_cen_q;
                if (off == 5'd31) begin
                    ref_last_d = 1'b1;
                    clr        = 1'b1;
                    state_d    = DRAIN;
                end else begin
                    step = 1'b1;
                    if (!first_row_q && nxt_ok) begin
                        ram_cen_d  = 1'b0;
                        ram_addr_d = nxt_addr;
                    end else begin
                        ram_cen_d  = 1'b1;
                    end
                end
            end
            DRAIN: begin
                wr_ready_d = 1'b1;
                state_d    = WR;
            end
            WR: begin
                wr_ready_d = 1'b1;
                if (wr_valid_i && wr_ready_q) begin
                    step = 1'b1;
                    // Words beyond the frame edge are accepted but never reach the RAM.
                    if (cur_ok) begin
                        ram_cen_d  = 1'b0;
                        ram_wen_d  = 1'b0;
                        ram_addr_d = cur_addr;
                        ram_data_d = wr_data_i;
                    end else begin
                        ram_cen_d  = 1'b1;
                    end
                    if (off == 5'd15) begin
                        clr        = 1'b1;
                        wr_ready_d = 1'b0;
                        done_d     = 1'b1;
                        state_d    = IDLE;
                    end else begin
                        state_d = WR;
                    end
                end else begin
                    state_d = WR;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Control, reference-stream and RAM interface registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            first_row_q <= 1'b0;
            ref_valid_q <= 1'b0;
            ref_last_q  <= 1'b0;
            ref_hit_q   <= 1'b0;
            ref_idx_q   <= 5'd0;
            wr_ready_q  <= 1'b0;
            done_q      <= 1'b0;
            ram_cen_q   <= 1'b1;
            ram_wen_q   <= 1'b1;
            ram_addr_q  <= {ADDR_W{1'b0}};
            ram_data_q  <= {WORD_W{1'b0}};
        end else begin
            state_q     <= state_d;
            first_row_q <= first_row_d;
            ref_valid_q <= ref_valid_d;
            ref_last_q  <= ref_last_d;
            ref_hit_q   <= ref_hit_d;
            ref_idx_q   <= ref_idx_d;
            wr_ready_q  <= wr_ready_d;
            done_q      <= done_d;
            ram_cen_q   <= ram_cen_d;
            ram_wen_q   <= ram_wen_d;
            ram_addr_q  <= ram_addr_d;
            ram_data_q  <= ram_data_d;
        end
    end

`ifdef INTRA_TOPRIGHT_PAD_EN
    logic [WORD_W-1:0] pad_word_q, pad_word_d;

    // Remember the most recent RAM word of this LCU; restarts at the default word on every start.
    always_comb begin
        if (load) begin
            pad_word_d = DFLT_WORD;
        end else if (ref_hit_q) begin
            pad_word_d = ram_data_i;
        end else begin
            pad_word_d = pad_word_q;
        end
    end

    // Pad word register.
    always_ff @(posedge clk) begin
        if (rst) begin
            pad_word_q <= DFLT_WORD;
        end else begin
            pad_word_q <= pad_word_d;
        end
    end

    assign pad_word = pad_word_q;
`else
    assign pad_word = DFLT_WORD;
`endif

    // RAM read data arrives the cycle the slot is reported, so the data path is a mux, not a register.
    always_comb begin
        if (!ref_valid_q) begin
            ref_data_o = {WORD_W{1'b0}};
        end else if (first_row_q) begin
            ref_data_o = DFLT_WORD;
        end else if (ref_hit_q) begin
            ref_data_o = ram_data_i;
        end else begin
            ref_data_o = pad_word;
        end
    end

    assign ref_valid_o = ref_valid_q;
    assign ref_idx_o   = ref_idx_q;
    assign ref_last_o  = ref_last_q;
    assign wr_ready_o  = wr_ready_q;
    assign done_o      = done_q;
    assign ram_cen_o   = ram_cen_q;
    assign ram_wen_o   = ram_wen_q;
    assign ram_addr_o  = ram_addr_q;
    assign ram_data_o  = ram_data_q;
endmodule

// File: tb/tb_intra_row_ref_ctrl.sv
// Directed bench for intra_row_ref_ctrl: RAM model holds word n at address n; writes are checked at the RAM port.
module tb_intra_row_ref_ctrl;
    localparam logic [31:0] DFLT = 32'h8080_8080;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_i;
    logic [5:0]  lcu_x_i;
    logic [8:0]  frame_w_words_i;
    logic        first_row_i;
    logic        ref_valid_o;
    logic [31:0] ref_data_o;
    logic [4:0]  ref_idx_o;
    logic        ref_last_o;
    logic        wr_valid_i;
    logic [31:0] wr_data_i;
    logic        wr_ready_o;
    logic        done_o;
    logic        ram_cen_o;
    logic        ram_wen_o;
    logic [8:0]  ram_addr_o;
    logic [31:0] ram_data_o;
    logic [31:0] ram_data_i;

    logic [31:0] mem [0:511];
    int n_tests = 0;
    int n_fail  = 0;

    intra_row_ref_ctrl dut (
        .clk             (clk),
        .rst             (rst),
        .start_i         (start_i),
        .lcu_x_i         (lcu_x_i),
        .frame_w_words_i (frame_w_words_i),
        .first_row_i     (first_row_i),
        .ref_valid_o     (ref_valid_o),
        .ref_data_o      (ref_data_o),
        .ref_idx_o       (ref_idx_o),
        .ref_last_o      (ref_last_o),
        .wr_valid_i      (wr_valid_i),
        .wr_data_i       (wr_data_i),
        .wr_ready_o      (wr_ready_o),
        .done_o          (done_o),
        .ram_cen_o       (ram_cen_o),
        .ram_wen_o       (ram_wen_o),
        .ram_addr_o      (ram_addr_o),
        .ram_data_o      (ram_data_o),
        .ram_data_i      (ram_data_i)
    );

    always #5 clk = ~clk;

    // Read-only RAM model with one cycle of read latency.
    always @(posedge clk) begin
        if (!ram_cen_o && ram_wen_o) ram_data_i <= mem[ram_addr_o];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " ref_valid"}, 32'(ref_valid_o), 32'd0);
        check({tag, " ref_last"},  32'(ref_last_o),  32'd0);
        check({tag, " ref_data"},  ref_data_o,       32'd0);
        check({tag, " ref_idx"},   32'(ref_idx_o),   32'd0);
        check({tag, " wr_ready"},  32'(wr_ready_o),  32'd0);
        check({tag, " done"},      32'(done_o),      32'd0);
        check({tag, " ram_cen"},   32'(ram_cen_o),   32'd1);
        check({tag, " ram_wen"},   32'(ram_wen_o),   32'd1);
        check({tag, " ram_addr"},  32'(ram_addr_o),  32'd0);
        check({tag, " ram_data"},  ram_data_o,       32'd0);
    endtask

    task automatic run_lcu(input string tag, input int x, input int w, input bit fr,
                           input bit toggle, input bit spam);
        logic [31:0] got_data [32];
        int          got_idx  [32];
        logic        got_last [32];
        logic [31:0] wa [$];
        logic [31:0] wd [$];
        int n_out = 0, n_rd = 0, n_done = 0, acc = 0, phase = 0;
        int c_first = -1, c_done = -1, c_acc16 = -1;
        int base = x * 16;
        int exp_rd = 0, n_wr = 0;
        logic [31:0] last = DFLT;
        logic [31:0] e;

        @(negedge clk);
        start_i = 1'b1; lcu_x_i = 6'(x); frame_w_words_i = 9'(w); first_row_i = fr;
        for (int c = 0; c < 120; c++) begin
            @(negedge clk);
            if (ref_valid_o) begin
                if (n_out < 32) begin
                    got_data[n_out] = ref_data_o;
                    got_idx[n_out]  = int'(ref_idx_o);
                    got_last[n_out] = ref_last_o;
                end
                if (n_out == 0) c_first = c;
                n_out++;
            end
            if (!ram_cen_o && ram_wen_o) n_rd++;
            if (!ram_cen_o && !ram_wen_o) begin
                wa.push_back(32'(ram_addr_o));
                wd.push_back(ram_data_o);
            end
            if (done_o) begin
                n_done++;
                if (c_done < 0) c_done = c;
            end
            start_i = spam && (c == 5 || c == 40);
            if (wr_ready_o) begin
                wr_valid_i = toggle ? (phase % 2 == 0) : 1'b1;
                phase++;
            end else begin
                wr_valid_i = !toggle;
            end
            wr_data_i = 32'hC0DE_0000 + 32'(acc);
            if (wr_valid_i && wr_ready_o) begin
                acc++;
                if (acc == 16) c_acc16 = c;
            end
        end
        wr_valid_i = 1'b0;
        start_i    = 1'b0;

        check({tag, " out count"}, 32'(n_out), 32'd32);
        check({tag, " first out latency"}, 32'(c_first), 32'd1);
        for (int k = 0; k < 32; k++) begin
            if (fr) e = DFLT;
            else if (base + k < w) begin e = 32'(base + k); last = e; exp_rd++; end
`ifdef INTRA_TOPRIGHT_PAD_EN
            else e = last;
`else
            else e = DFLT;
`endif
            check($sformatf("%s idx%0d", tag, k),  32'(got_idx[k]),  32'(k));
            check($sformatf("%s data%0d", tag, k), got_data[k],      e);
            check($sformatf("%s last%0d", tag, k), 32'(got_last[k]), 32'(k == 31));
        end
        check({tag, " read count"}, 32'(n_rd), 32'(exp_rd));
        for (int j = 0; j < 16; j++) begin
            if (base + j < w) begin
                if (n_wr < wa.size()) begin
                    check($sformatf("%s wr addr%0d", tag, j), wa[n_wr], 32'(base + j));
                    check($sformatf("%s wr data%0d", tag, j), wd[n_wr], 32'hC0DE_0000 + 32'(j));
                end
                n_wr++;
            end
        end
        check({tag, " write count"}, 32'(wa.size()), 32'(n_wr));
        check({tag, " accepted"}, 32'(acc), 32'd16);
        check({tag, " done pulses"}, 32'(n_done), 32'd1);
        check({tag, " done after 16th accept"}, 32'(c_done), 32'(c_acc16 + 1));
        check({tag, " ready idle"}, 32'(wr_ready_o), 32'd0);
    endtask

    initial begin
        int stray;
        for (int n = 0; n < 512; n++) mem[n] = 32'(n);
        rst = 1'b1; start_i = 1'b0; lcu_x_i = 6'd0; frame_w_words_i = 9'd0;
        first_row_i = 1'b0; wr_valid_i = 1'b0; wr_data_i = 32'd0;
        repeat (3) @(negedge clk);
        check_reset_outputs("por");
        rst = 1'b0;

        run_lcu("basic",    2,  480, 1'b0, 1'b0, 1'b0);
        run_lcu("edge",     29, 472, 1'b0, 1'b0, 1'b0);
        run_lcu("firstrow", 5,  480, 1'b1, 1'b0, 1'b0);
        run_lcu("spam",     2,  480, 1'b0, 1'b0, 1'b1);
        run_lcu("toggle",   4,  480, 1'b0, 1'b1, 1'b0);

        // Reset while slot 10 is on the RAM port.
        @(negedge clk);
        start_i = 1'b1; lcu_x_i = 6'd2; frame_w_words_i = 9'd480; first_row_i = 1'b0;
        @(negedge clk);
        start_i = 1'b0;
        repeat (10) @(negedge clk);
        check("midrd slot10 addr", 32'(ram_addr_o), 32'd42);
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs("midrd");
        rst = 1'b0;
        wr_valid_i = 1'b1;
        stray = 0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (ref_valid_o || wr_ready_o || done_o || !ram_cen_o) stray++;
        end
        wr_valid_i = 1'b0;
        check("midrd no resume", 32'(stray), 32'd0);
        run_lcu("afterrst", 7, 480, 1'b0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
